// File: rtl/rs_chunked_alu_seq.sv
// Multi-cycle WIDTH-bit add/subtract built from one CHUNK-wide adder.
// Slices are processed LSB-first; the inter-slice carry lives in carry_q.
module rs_chunked_alu_seq #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             bi,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             co,
    output logic             busy
);

    localparam int NCH   = WIDTH / CHUNK;
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

    generate
        if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_param
            $error("rs_chunked_alu_seq: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   bb_q;
    logic               carry_q;
    logic [IDX_W-1:0]   idx;
    logic [CHUNK:0]     sum;

    // Operands are shifted right each RUN cycle, so the current slice is always in the low bits.
    always_comb begin
        sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, bb_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
    end

    // NOTE: in_ready must drop the moment rst rises, before the async reset has any edge to act on.
    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // NOTE: all state updates are non-blocking so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            a_q     <= '0;
            bb_q    <= '0;
            carry_q <= 1'b0;
            idx     <= '0;
            y       <= '0;
            co      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        bb_q    <= bi ? ~b : b;
                        carry_q <= ci;
                        idx     <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> CHUNK;
                    bb_q    <= bb_q >> CHUNK;
                    carry_q <= sum[CHUNK];
                    // Result slices enter at the top and settle into place after NCH shifts.
                    y       <= (y >> CHUNK) | (WIDTH'(sum[CHUNK-1:0]) << (WIDTH - CHUNK));
                    idx     <= idx + IDX_W'(1);
                    if (idx == LAST_IDX) begin
                        co    <= sum[CHUNK];
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rs_chunked_alu_seq.sv
// Directed and scoreboard bench for rs_chunked_alu_seq in the 64/16 and 16/16 configurations.
module tb_rs_chunked_alu_seq;

    logic clk;
    logic rst;

    logic        w_in_valid, w_in_ready, w_ci, w_bi, w_out_valid, w_out_ready, w_co, w_busy;
    logic [63:0] w_a, w_b, w_y;
    logic        n_in_valid, n_in_ready, n_ci, n_bi, n_out_valid, n_out_ready, n_co, n_busy;
    logic [15:0] n_a, n_b, n_y;

    int checks;
    int errors;

    rs_chunked_alu_seq #(.WIDTH(64), .CHUNK(16)) dut_w (
        .clk(clk), .rst(rst),
        .in_valid(w_in_valid), .in_ready(w_in_ready),
        .a(w_a), .b(w_b), .ci(w_ci), .bi(w_bi),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .y(w_y), .co(w_co), .busy(w_busy)
    );

    rs_chunked_alu_seq #(.WIDTH(16), .CHUNK(16)) dut_n (
        .clk(clk), .rst(rst),
        .in_valid(n_in_valid), .in_ready(n_in_ready),
        .a(n_a), .b(n_b), .ci(n_ci), .bi(n_bi),
        .out_valid(n_out_valid), .out_ready(n_out_ready),
        .y(n_y), .co(n_co), .busy(n_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [64:0] ref64(input logic [63:0] av, input logic [63:0] bv,
                                          input logic civ, input logic biv);
        logic [63:0] bb;
        bb = biv ? ~bv : bv;
        return {1'b0, av} + {1'b0, bb} + {64'd0, civ};
    endfunction

    function automatic logic [16:0] ref16(input logic [15:0] av, input logic [15:0] bv,
                                          input logic civ, input logic biv);
        logic [15:0] bb;
        bb = biv ? ~bv : bv;
        return {1'b0, av} + {1'b0, bb} + {16'd0, civ};
    endfunction

    // One full transaction on the 64-bit instance; lat counts edges from accept to out_valid.
    task automatic op64(input logic [63:0] av, input logic [63:0] bv, input logic civ, input logic biv,
                        output logic [63:0] yv, output logic cov, output int lat);
        int guard;
        guard = 0;
        while (!w_in_ready && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        w_a = av; w_b = bv; w_ci = civ; w_bi = biv; w_in_valid = 1'b1;
        @(posedge clk); #1;
        w_in_valid = 1'b0;
        lat = 0;
        while (!w_out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        yv = w_y; cov = w_co;
        w_out_ready = 1'b1;
        @(posedge clk); #1;
        w_out_ready = 1'b0;
    endtask

    task automatic op16(input logic [15:0] av, input logic [15:0] bv, input logic civ, input logic biv,
                        output logic [15:0] yv, output logic cov, output int lat);
        int guard;
        guard = 0;
        while (!n_in_ready && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        n_a = av; n_b = bv; n_ci = civ; n_bi = biv; n_in_valid = 1'b1;
        @(posedge clk); #1;
        n_in_valid = 1'b0;
        lat = 0;
        while (!n_out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        yv = n_y; cov = n_co;
        n_out_ready = 1'b1;
        @(posedge clk); #1;
        n_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({w_in_ready, w_out_valid, w_busy, w_co} !== 4'b0000 || w_y !== 64'd0) begin
            errors++;
            $display("FAIL reset_w: rdy=%b vld=%b busy=%b co=%b y=%h, required 0/0/0/0/0",
                     w_in_ready, w_out_valid, w_busy, w_co, w_y);
        end
        checks++;
        if ({n_in_ready, n_out_valid, n_busy, n_co} !== 4'b0000 || n_y !== 16'd0) begin
            errors++;
            $display("FAIL reset_n: rdy=%b vld=%b busy=%b co=%b y=%h, required 0/0/0/0/0",
                     n_in_ready, n_out_valid, n_busy, n_co, n_y);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if (w_in_ready !== 1'b1 || n_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: in_ready w=%b n=%b, required 1/1", w_in_ready, n_in_ready);
        end
    endtask

    task automatic test_carry_ripple();
        logic [63:0] yv; logic cov; int lat;
        op64(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, yv, cov, lat);
        checks++;
        if (yv !== 64'd0) begin errors++; $display("FAIL ripple_y: got %h, required 0", yv); end
        checks++;
        if (cov !== 1'b1) begin errors++; $display("FAIL ripple_co: got %b, required 1", cov); end
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL ripple_latency: got %0d, required 4", lat); end
    endtask

    task automatic test_subtract();
        logic [63:0] yv; logic cov; int lat;
        op64(64'd5, 64'd7, 1'b1, 1'b1, yv, cov, lat);
        checks++;
        if (yv !== 64'hFFFF_FFFF_FFFF_FFFE) begin
            errors++; $display("FAIL sub_5_7_y: got %h, required fffffffffffffffe", yv);
        end
        checks++;
        if (cov !== 1'b0) begin errors++; $display("FAIL sub_5_7_co: got %b, required 0", cov); end
        op64(64'd7, 64'd5, 1'b1, 1'b1, yv, cov, lat);
        checks++;
        if (yv !== 64'd2) begin errors++; $display("FAIL sub_7_5_y: got %h, required 2", yv); end
        checks++;
        if (cov !== 1'b1) begin errors++; $display("FAIL sub_7_5_co: got %b, required 1", cov); end
    endtask

    task automatic test_back_pressure();
        int lat;
        w_a = 64'h1234_0000_0000_0001; w_b = 64'h0000_0000_0000_FFFF;
        w_ci = 1'b0; w_bi = 1'b0; w_in_valid = 1'b1; w_out_ready = 1'b0;
        @(posedge clk); #1;
        w_in_valid = 1'b0;
        lat = 0;
        while (!w_out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL bp_latency: got %0d, required 4", lat); end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (w_y !== 64'h1234_0000_0001_0000 || w_co !== 1'b0 || w_out_valid !== 1'b1 ||
                w_in_ready !== 1'b0 || w_busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold[%0d]: y=%h co=%b vld=%b rdy=%b busy=%b, required 1234000000010000/0/1/0/1",
                         i, w_y, w_co, w_out_valid, w_in_ready, w_busy);
            end
            @(posedge clk); #1;
        end
        w_out_ready = 1'b1;
        @(posedge clk); #1;
        w_out_ready = 1'b0;
        checks++;
        if (w_in_ready !== 1'b1 || w_out_valid !== 1'b0 || w_busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: rdy=%b vld=%b busy=%b, required 1/0/0", w_in_ready, w_out_valid, w_busy);
        end
    endtask

    task automatic test_busy_noise();
        int lat;
        w_a = 64'h1111_1111_1111_1111; w_b = 64'h2222_2222_2222_2222;
        w_ci = 1'b1; w_bi = 1'b0; w_in_valid = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        while (!w_out_valid && lat < 20) begin
            w_a = {$urandom, $urandom}; w_b = {$urandom, $urandom};
            w_ci = 1'($urandom); w_bi = 1'($urandom); w_in_valid = 1'($urandom);
            @(posedge clk); #1; lat++;
        end
        w_in_valid = 1'b0;
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL noise_latency: got %0d, required 4", lat); end
        checks++;
        if (w_y !== 64'h3333_3333_3333_3334 || w_co !== 1'b0) begin
            errors++; $display("FAIL noise_result: y=%h co=%b, required 3333333333333334/0", w_y, w_co);
        end
        w_out_ready = 1'b1;
        @(posedge clk); #1;
        w_out_ready = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (w_in_ready !== 1'b1 || w_busy !== 1'b0) begin
            errors++; $display("FAIL noise_extra_accept: rdy=%b busy=%b, required 1/0", w_in_ready, w_busy);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [63:0] yv; logic cov; int lat;
        w_a = 64'hFFFF_FFFF_FFFF_FFFF; w_b = 64'h0123_4567_89AB_CDEF;
        w_ci = 1'b1; w_bi = 1'b0; w_in_valid = 1'b1;
        @(posedge clk); #1;
        w_in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({w_out_valid, w_co, w_busy, w_in_ready} !== 4'b0000 || w_y !== 64'd0) begin
            errors++;
            $display("FAIL midrun_reset: vld=%b co=%b busy=%b rdy=%b y=%h, required all 0",
                     w_out_valid, w_co, w_busy, w_in_ready, w_y);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if (w_in_ready !== 1'b1 || w_out_valid !== 1'b0) begin
            errors++; $display("FAIL midrun_release: rdy=%b vld=%b, required 1/0", w_in_ready, w_out_valid);
        end
        op64(64'd1, 64'd1, 1'b0, 1'b0, yv, cov, lat);
        checks++;
        if (yv !== 64'd2 || cov !== 1'b0 || lat !== 4) begin
            errors++; $display("FAIL midrun_next_op: y=%h co=%b lat=%0d, required 2/0/4", yv, cov, lat);
        end
    endtask

    task automatic test_nch1();
        logic [15:0] yv; logic cov; int lat;
        op16(16'h8000, 16'h8000, 1'b0, 1'b0, yv, cov, lat);
        checks++;
        if (yv !== 16'd0 || cov !== 1'b1) begin
            errors++; $display("FAIL nch1_result: y=%h co=%b, required 0000/1", yv, cov);
        end
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL nch1_latency: got %0d, required 1", lat); end
    endtask

    task automatic rand64(input int n);
        logic [63:0] av, bv, yv; logic civ, biv, cov; logic [64:0] exp; int lat; int shown;
        shown = 0;
        for (int i = 0; i < n; i++) begin
            av = {$urandom, $urandom}; bv = {$urandom, $urandom};
            if (i % 8 == 0) av = 64'hFFFF_FFFF_FFFF_FFFF;
            if (i % 16 == 1) bv = 64'd0;
            civ = 1'($urandom); biv = 1'($urandom);
            exp = ref64(av, bv, civ, biv);
            op64(av, bv, civ, biv, yv, cov, lat);
            checks++;
            if (yv !== exp[63:0] || cov !== exp[64] || lat !== 4) begin
                errors++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL rand64[%0d]: y=%h co=%b lat=%0d, required %h/%b/4",
                             i, yv, cov, lat, exp[63:0], exp[64]);
                end
            end
        end
    endtask

    task automatic rand16(input int n);
        logic [15:0] av, bv, yv; logic civ, biv, cov; logic [16:0] exp; int lat; int shown;
        shown = 0;
        for (int i = 0; i < n; i++) begin
            av = 16'($urandom); bv = 16'($urandom);
            civ = 1'($urandom); biv = 1'($urandom);
            exp = ref16(av, bv, civ, biv);
            op16(av, bv, civ, biv, yv, cov, lat);
            checks++;
            if (yv !== exp[15:0] || cov !== exp[16] || lat !== 1) begin
                errors++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL rand16[%0d]: y=%h co=%b lat=%0d, required %h/%b/1",
                             i, yv, cov, lat, exp[15:0], exp[16]);
                end
            end
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1;
        w_in_valid = 1'b0; w_out_ready = 1'b0; w_a = '0; w_b = '0; w_ci = 1'b0; w_bi = 1'b0;
        n_in_valid = 1'b0; n_out_ready = 1'b0; n_a = '0; n_b = '0; n_ci = 1'b0; n_bi = 1'b0;
        test_reset();
        test_carry_ripple();
        test_subtract();
        test_back_pressure();
        test_busy_noise();
        test_reset_mid_run();
        test_nch1();
        fork
            rand64(10000);
            rand16(10000);
        join
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
